ifmap_fill_ctrl: RTL and testbench

IFMAP_FILL_CTRL -- requirements
Module: ifmap_fill_ctrl

---
 rtl/ifmap_pkg.sv | 26 ++
 rtl/ifmap_lane_credit.sv | 62 ++++++
 rtl/ifmap_fill_ctrl.sv | 124 ++++++++++++
 tb/tb_ifmap_fill_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_pkg.sv
// ifmap_pkg: shared sizing constants, FSM encoding and helpers
// for the input-feature-map FIFO fill controller.
package ifmap_pkg;

    localparam int NUM_FIFOS  = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int LANE_CFG_W = 6;
    localparam int WORDS_W    = 16;
    localparam int TOTAL_W    = LANE_CFG_W + WORDS_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [LANE_CFG_W-1:0] clamp_lanes(
        input logic [LANE_CFG_W-1:0] req,
        input logic [LANE_CFG_W-1:0] max_lanes
    );
        return (req > max_lanes) ? max_lanes : req;
    endfunction

endpackage

// File: rtl/ifmap_lane_credit.sv
// ifmap_lane_credit: write credit and saturating pop counter
// for a single ifmap FIFO lane.
module ifmap_lane_credit
    import ifmap_pkg::*;
#(
    parameter int FIFO_DEPTH = ifmap_pkg::FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               take,
    input  logic               pop_ok,
    input  logic               count_en,
    input  logic [WORDS_W-1:0] words,
    output logic               has_credit,
    output logic               fin
);

    localparam int CR_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CR_W-1:0] FULL_CREDIT = CR_W'(FIFO_DEPTH);

    logic [CR_W-1:0]    credit_q;
    logic [CR_W-1:0]    credit_d;
    logic [WORDS_W-1:0] cnt_q;
    logic [WORDS_W-1:0] cnt_d;

    // A take and a pop in the same cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        unique case (1'b1)
            take && !pop_ok:
                credit_d = credit_q - CR_W'(1);
            pop_ok && !take && (credit_q != FULL_CREDIT):
                credit_d = credit_q + CR_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (count_en && pop_ok && (cnt_q != words)) begin
            cnt_d = cnt_q + WORDS_W'(1);
        end
    end

    // fin looks at the next count so DONE follows the last pop directly.
    assign has_credit = (credit_q != '0);
    assign fin        = (cnt_d == words);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= FULL_CREDIT;
            cnt_q    <= '0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ifmap_fill_ctrl.sv
// ifmap_fill_ctrl: distributes a GLB read stream round-robin
// into per-lane ifmap FIFOs under credit-based flow control.
module ifmap_fill_ctrl
    import ifmap_pkg::*;
#(
    parameter int NUM_FIFOS  = ifmap_pkg::NUM_FIFOS,
    parameter int FIFO_DEPTH = ifmap_pkg::FIFO_DEPTH,
    parameter int DATA_WIDTH = ifmap_pkg::DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LANE_CFG_W-1:0]                cfg_lanes,
    input  logic [WORDS_W-1:0]                   cfg_words,
    input  logic                                 rd_valid,
    input  logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_ready,
    output logic [NUM_FIFOS-1:0]                 push,
    output logic [NUM_FIFOS-1:0][DATA_WIDTH-1:0] push_data,
    input  logic [NUM_FIFOS-1:0]                 pop,
    input  logic [NUM_FIFOS-1:0]                 not_empty,
    output logic                                 busy,
    output logic                                 done
);

    localparam int LANE_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam logic [LANE_CFG_W-1:0] MAX_LANES = LANE_CFG_W'(NUM_FIFOS);

    state_t                  state_q;
    state_t                  state_d;
    logic [LANE_CFG_W-1:0]   lanes_q;
    logic [WORDS_W-1:0]      words_q;
    logic [TOTAL_W-1:0]      total_q;
    logic [TOTAL_W-1:0]      hs_cnt_q;
    logic [LANE_W-1:0]       lane_q;
    logic [LANE_CFG_W-1:0]   lanes_req;
    logic                    accept;
    logic                    hs;
    logic                    last_hs;
    logic                    lane_wrap;
    logic                    all_fin;
    logic [NUM_FIFOS-1:0]    has_credit;
    logic [NUM_FIFOS-1:0]    fin;
    logic [NUM_FIFOS-1:0]    active;
    logic [NUM_FIFOS-1:0]    take;

    assign lanes_req = clamp_lanes(cfg_lanes, MAX_LANES);
    assign accept    = (state_q == ST_IDLE) && start;
    assign rd_ready  = (state_q == ST_FILL) && has_credit[lane_q];
    assign hs        = rd_valid && rd_ready;
    assign last_hs   = hs && ((hs_cnt_q + TOTAL_W'(1)) == total_q);
    assign lane_wrap = (LANE_CFG_W'(lane_q) == (lanes_q - LANE_CFG_W'(1)));
    assign all_fin   = &(fin | ~active);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((cfg_lanes == '0) || (cfg_words == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL:  if (last_hs) state_d = ST_DRAIN;
            ST_DRAIN: if (all_fin) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lanes_q   <= '0;
            words_q   <= '0;
            total_q   <= '0;
            hs_cnt_q  <= '0;
            lane_q    <= '0;
            push      <= '0;
            push_data <= '0;
        end else begin
            state_q <= state_d;
            push    <= '0;
            if (accept) begin
                lanes_q  <= lanes_req;
                words_q  <= cfg_words;
                total_q  <= TOTAL_W'(lanes_req) * TOTAL_W'(cfg_words);
                hs_cnt_q <= '0;
                lane_q   <= '0;
            end
            if (hs) begin
                push[lane_q]      <= 1'b1;
                push_data[lane_q] <= rd_data;
                hs_cnt_q          <= hs_cnt_q + TOTAL_W'(1);
                lane_q            <= lane_wrap ? '0 : lane_q + LANE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_lane
        assign active[i] = (LANE_CFG_W'(i) < lanes_q);
        assign take[i]   = hs && (lane_q == LANE_W'(i));

        ifmap_lane_credit #(
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_credit (
            .clk        (clk),
            .rst        (rst),
            .clr        (accept),
            .take       (take[i]),
            .pop_ok     (pop[i] & not_empty[i]),
            .count_en   (busy & active[i]),
            .words      (words_q),
            .has_credit (has_credit[i]),
            .fin        (fin[i])
        );
    end

endmodule

// File: tb/tb_ifmap_fill_ctrl.sv
// tb_ifmap_fill_ctrl: randomized bench with a FIFO-occupancy
// reference model for the ifmap fill controller.
module tb_ifmap_fill_ctrl;

    localparam int N = 32;
    localparam int D = 4;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [5:0]          cfg_lanes;
    logic [15:0]         cfg_words;
    logic                rd_valid;
    logic [W-1:0]        rd_data;
    logic                rd_ready;
    logic [N-1:0]        push;
    logic [N-1:0][W-1:0] push_data;
    logic [N-1:0]        pop;
    logic [N-1:0]        not_empty;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    ifmap_fill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_lanes (cfg_lanes),
        .cfg_words (cfg_words),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .not_empty (not_empty),
        .busy      (busy),
        .done      (done)
    );

    typedef enum {M_IDLE, M_FILL, M_DRAIN, M_DONE} mph_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    mph_t         ph = M_IDLE;
    int           m_lanes = 1;
    int           m_words = 0;
    int           k = 0;
    int           infl = -1;
    logic [W-1:0] infl_data;
    logic [W-1:0] cur_word;
    int           occ[N];
    int           popc[N];
    int           vprob = 100;
    int           pprob = 100;
    bit           force_ne = 1'b0;
    int           obs_log[$];
    int           obs_done = 0;

    // Free space seen by the stream: depth minus stored and in-flight words.
    function automatic bit exp_ready();
        int l;
        if (ph != M_FILL) return 1'b0;
        l = k % m_lanes;
        return (D - occ[l] - ((infl == l) ? 1 : 0)) > 0;
    endfunction

    task automatic model_reset();
        ph   = M_IDLE;
        infl = -1;
        k    = 0;
        for (int i = 0; i < N; i++) begin
            occ[i]  = 0;
            popc[i] = 0;
        end
    endtask

    task automatic drive_inputs();
        rd_valid = ($urandom_range(99) < vprob);
        rd_data  = cur_word;
        for (int i = 0; i < N; i++) begin
            pop[i]       = ((occ[i] > 0) || force_ne) && ($urandom_range(99) < pprob);
            not_empty[i] = (occ[i] > 0) || force_ne;
        end
    endtask

    task automatic step();
        bit           hs;
        bit           all_fin;
        logic [N-1:0] exp_push;
        hs = rd_valid && exp_ready();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ph == M_FILL || ph == M_DRAIN)
                for (int i = 0; i < m_lanes; i++)
                    if (pop[i] && not_empty[i] && popc[i] < m_words) popc[i]++;
            for (int i = 0; i < N; i++)
                if (pop[i] && occ[i] > 0) occ[i]--;
            if (infl >= 0) begin
                occ[infl]++;
                n_cmp++;
                if (occ[infl] > D) begin
                    n_bad++;
                    $display("FAIL fifo_overflow lane %0d occupancy %0d, limit %0d",
                             infl, occ[infl], D);
                end
            end
            infl = -1;
            case (ph)
                M_IDLE: if (start) begin
                    m_lanes = (cfg_lanes > 6'd32) ? 32 : int'(cfg_lanes);
                    m_words = int'(cfg_words);
                    k = 0;
                    for (int i = 0; i < N; i++) popc[i] = 0;
                    ph = (m_lanes == 0 || m_words == 0) ? M_DONE : M_FILL;
                end
                M_FILL: if (hs) begin
                    infl      = k % m_lanes;
                    infl_data = cur_word;
                    k++;
                    cur_word  = $urandom();
                    if (k == m_lanes * m_words) ph = M_DRAIN;
                end
                M_DRAIN: begin
                    all_fin = 1'b1;
                    for (int i = 0; i < m_lanes; i++)
                        if (popc[i] != m_words) all_fin = 1'b0;
                    if (all_fin) ph = M_DONE;
                end
                default: ph = M_IDLE;
            endcase
        end
        #1;
        exp_push = '0;
        if (infl >= 0) exp_push[infl] = 1'b1;
        n_cmp++;
        if (push !== exp_push) begin
            n_bad++;
            $display("FAIL push got %h want %h", push, exp_push);
        end
        if (infl >= 0) begin
            n_cmp++;
            if (push_data[infl] !== infl_data) begin
                n_bad++;
                $display("FAIL push_data lane %0d got %h want %h",
                         infl, push_data[infl], infl_data);
            end
        end
        n_cmp++;
        if (rd_ready !== exp_ready()) begin
            n_bad++;
            $display("FAIL rd_ready got %b want %b", rd_ready, exp_ready());
        end
        n_cmp++;
        if (busy !== (ph == M_FILL || ph == M_DRAIN)) begin
            n_bad++;
            $display("FAIL busy got %b in phase %s", busy, ph.name());
        end
        n_cmp++;
        if (done !== (ph == M_DONE)) begin
            n_bad++;
            $display("FAIL done got %b in phase %s", done, ph.name());
        end
        for (int i = 0; i < N; i++)
            if (push[i] === 1'b1) obs_log.push_back(i);
        if (done === 1'b1) obs_done++;
        drive_inputs();
    endtask

    task automatic begin_job(input int l, input int w);
        cfg_lanes = 6'(l);
        cfg_words = 16'(w);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic finish_job(input int budget);
        int c = 0;
        while (ph != M_IDLE && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        if (ph != M_IDLE) begin
            n_bad++;
            $display("FAIL job_timeout phase %s after %0d cycles, want IDLE", ph.name(), c);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_lanes = '0; cfg_words = '0;
        rd_valid = 1'b0; cur_word = $urandom(); rd_data = cur_word;
        pop = '0; not_empty = '0;
        step();
        step();
        n_cmp++;
        if (push_data !== '0) begin
            n_bad++;
            $display("FAIL reset_push_data got nonzero %h", push_data);
        end
        n_cmp++;
        if (rd_ready !== 1'b0 || push !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs rd_ready %b push %h, want 0/0", rd_ready, push);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int d0;
        vprob = 100; pprob = 100;
        obs_log.delete();
        d0 = obs_done;
        begin_job(2, 3);
        finish_job(100);
        n_cmp++;
        if (obs_log.size() != 6) begin
            n_bad++;
            $display("FAIL basic_push_count got %0d want 6", obs_log.size());
        end
        for (int i = 0; i < obs_log.size() && i < 6; i++) begin
            n_cmp++;
            if (obs_log[i] != i % 2) begin
                n_bad++;
                $display("FAIL basic_lane_order push %0d got lane %0d want %0d",
                         i, obs_log[i], i % 2);
            end
        end
        n_cmp++;
        if (obs_done != d0 + 1) begin
            n_bad++;
            $display("FAIL basic_done_pulses got %0d want 1", obs_done - d0);
        end
    endtask

    task automatic test_no_pop();
        vprob = 100; pprob = 0;
        obs_log.delete();
        begin_job(1, 6);
        repeat (10) step();
        n_cmp++;
        if (obs_log.size() != 4) begin
            n_bad++;
            $display("FAIL nopop_pushes got %0d want 4", obs_log.size());
        end
        n_cmp++;
        if (rd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL nopop_stall rd_ready got %b want 0", rd_ready);
        end
        pop[0] = 1'b1;
        step();
        repeat (8) step();
        n_cmp++;
        if (obs_log.size() != 5) begin
            n_bad++;
            $display("FAIL nopop_one_pop pushes got %0d want 5", obs_log.size());
        end
        pprob = 100;
        finish_job(200);
        n_cmp++;
        if (obs_log.size() != 6) begin
            n_bad++;
            $display("FAIL nopop_total pushes got %0d want 6", obs_log.size());
        end
    endtask

    task automatic test_same_cycle();
        vprob = 100; pprob = 0;
        begin_job(1, 12);
        repeat (8) step();
        pprob  = 100;
        pop[0] = 1'b1;
        step();
        repeat (5) begin
            n_cmp++;
            if (rd_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL same_cycle rd_ready got %b want 1", rd_ready);
            end
            step();
        end
        finish_job(200);
    endtask

    task automatic test_clamp();
        vprob = 70; pprob = 100;
        obs_log.delete();
        begin_job(40, 1);
        repeat (3) step();
        begin_job(1, 1);
        finish_job(600);
        n_cmp++;
        if (obs_log.size() != 32) begin
            n_bad++;
            $display("FAIL clamp_push_count got %0d want 32", obs_log.size());
        end
        for (int i = 0; i < obs_log.size() && i < 32; i++) begin
            n_cmp++;
            if (obs_log[i] != i) begin
                n_bad++;
                $display("FAIL clamp_lane push %0d got lane %0d want %0d", i, obs_log[i], i);
            end
        end
    endtask

    task automatic test_zero();
        int d0;
        obs_log.delete();
        d0 = obs_done;
        begin_job(7, 0);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_words done got %b want 1", done);
        end
        step();
        begin_job(0, 9);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_lanes done got %b want 1", done);
        end
        step();
        n_cmp++;
        if (obs_log.size() != 0 || obs_done != d0 + 2) begin
            n_bad++;
            $display("FAIL zero_jobs pushes %0d done %0d, want 0 pushes 2 done",
                     obs_log.size(), obs_done - d0);
        end
    endtask

    task automatic test_rst_mid();
        int c = 0;
        int d0;
        vprob = 100; pprob = 50;
        obs_log.delete();
        begin_job(32, 4);
        while (obs_log.size() < 5 && c < 50) begin
            step();
            c++;
        end
        n_cmp++;
        if (obs_log.size() != 5) begin
            n_bad++;
            $display("FAIL rst_mid_reach pushes got %0d want 5", obs_log.size());
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (push !== '0 || push_data !== '0 || rd_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs push %h rdy %b busy %b done %b, want all 0",
                     push, rd_ready, busy, done);
        end
        d0 = obs_done;
        repeat (10) step();
        n_cmp++;
        if (obs_done != d0) begin
            n_bad++;
            $display("FAIL rst_mid_no_done got %0d done pulses want 0", obs_done - d0);
        end
    endtask

    task automatic test_spurious();
        force_ne = 1'b1; vprob = 100; pprob = 100;
        repeat (6) step();
        force_ne = 1'b0; pprob = 0;
        obs_log.delete();
        begin_job(3, 8);
        repeat (20) step();
        n_cmp++;
        if (obs_log.size() != 12) begin
            n_bad++;
            $display("FAIL spurious_credit pushes got %0d want 12", obs_log.size());
        end
        pprob = 100;
        finish_job(300);
        n_cmp++;
        if (obs_log.size() != 24) begin
            n_bad++;
            $display("FAIL spurious_total pushes got %0d want 24", obs_log.size());
        end
    endtask

    task automatic test_random();
        repeat (6) begin
            vprob = $urandom_range(100, 30);
            pprob = $urandom_range(100, 20);
            begin_job($urandom_range(63), $urandom_range(6));
            finish_job(3000);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_pop();
        test_same_cycle();
        test_clamp();
        test_zero();
        test_rst_mid();
        test_spurious();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
